// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and sequencer in front of the shared data memory (dm).
//
// Port 0 is the CPU load/store stage, port 1 the debug/loader port. One request is
// latched at a time into a command register and presented to dm for exactly one
// cycle (ACCESS). Loads return registered data with a one-cycle rvalid pulse in the
// following RESP cycle; misaligned word/halfword accesses are dropped with an err pulse.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   reqN/weN/addrN        request, 1 = store, byte address (held until gntN)
//   wdataN/ldN/svN        store data, load type, store type
//   gntN                  one-cycle pulse: request accepted (visible during ACCESS)
//   rvalidN, rdata        one-cycle load-data pulse; rdata shared, holds until next load
//   errN                  one-cycle pulse: misaligned access dropped
//   dm_wr/dm_addr/dm_din  to dm DMWr/addr/din
//   dm_ld/dm_sv           to dm LD/SV
//   dm_dout               from dm dout (combinational read)
module dm_arbiter #(
  parameter int unsigned AW    = 9,
  parameter bit          PRIO0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic [2:0]    ld0,
  input  logic [2:0]    ld1,
  input  logic [1:0]    sv0,
  input  logic [1:0]    sv1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata,
  output logic          err0,
  output logic          err1,
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic [2:0]    dm_ld,
  output logic [1:0]    dm_sv,
  input  logic [31:0]   dm_dout
);

  // Load/store type codes shared with dm.
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;
  localparam logic [1:0] SV_SB  = 2'b00;
  localparam logic [1:0] SV_SH  = 2'b01;
  localparam logic [1:0] SV_SW  = 2'b10;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;        // port served most recently
  logic          cmd_port_q, cmd_port_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_wdata_q, cmd_wdata_d;
  logic [2:0]    cmd_ld_q, cmd_ld_d;
  logic [1:0]    cmd_sv_q, cmd_sv_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic any_req;
  logic win;
  logic misaligned;

  // Winner selection: a sole requester wins outright; on a tie either port 0
  // (fixed priority) or the port not served last.
  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) begin
      win = PRIO0 ? 1'b0 : ~last_q;
    end else begin
      win = ~req0;
    end
  end

  // Alignment check on the latched command. Byte accesses are never misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (cmd_we_q) begin
      if (cmd_sv_q == SV_SW) misaligned = (cmd_addr_q[1:0] != 2'b00);
      if (cmd_sv_q == SV_SH) misaligned = cmd_addr_q[0];
    end else begin
      if (cmd_ld_q == LD_LW) misaligned = (cmd_addr_q[1:0] != 2'b00);
      if ((cmd_ld_q == LD_LH) || (cmd_ld_q == LD_LHU)) misaligned = cmd_addr_q[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_ld_d    = cmd_ld_q;
    cmd_sv_d    = cmd_sv_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    err_d       = 2'b00;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          cmd_port_d  = win;
          cmd_we_d    = win ? we1    : we0;
          cmd_addr_d  = win ? addr1  : addr0;
          cmd_wdata_d = win ? wdata1 : wdata0;
          cmd_ld_d    = win ? ld1    : ld0;
          cmd_sv_d    = win ? sv1    : sv0;
          gnt_d[win]  = 1'b1;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        last_d = cmd_port_q;
        if (misaligned) begin
          err_d[cmd_port_q] = 1'b1;
          state_d           = StIdle;
        end else if (cmd_we_q) begin
          // Write commits on the edge leaving ACCESS via dm_wr below.
          state_d = StIdle;
        end else begin
          rdata_d              = dm_dout;
          rvalid_d[cmd_port_q] = 1'b1;
          state_d              = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_ld_q    <= LD_LW;
      cmd_sv_q    <= SV_SW;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      err_q       <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_ld_q    <= cmd_ld_d;
      cmd_sv_q    <= cmd_sv_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // dm_wr is decoded from the state register so an asynchronous reset drops it at once.
  assign dm_wr   = (state_q == StAccess) & cmd_we_q & ~misaligned;
  assign dm_addr = cmd_addr_q;
  assign dm_din  = cmd_wdata_q;
  assign dm_ld   = cmd_ld_q;
  assign dm_sv   = cmd_sv_q;

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign rdata   = rdata_q;

endmodule
